// File: rtl/shift_rx_deserializer.sv
// shift_rx_deserializer: synchronizes an external shift clock/data/latch and assembles MSB-first words
module shift_rx_deserializer #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serClk,
  input  logic                  serData,
  input  logic                  serLatch,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  input  logic                  dataReady,
  output logic                  overrun,
  output logic                  frameError
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t                state_q;
  logic [2:0]            sclk_q;
  logic [1:0]            sdat_q, slat_q;
  logic [CW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [TW-1:0]         to_q;
  logic                  rise, latch, busy, do_shift, last, abort, load, drop;
  assign rise     = sclk_q[1] & ~sclk_q[2];
  assign latch    = slat_q[1];
  assign shift_d  = {shift_q[DATA_WIDTH-2:0], sdat_q[1]};
  assign busy     = (state_q == SHIFT) && (bit_cnt_q != '0);
  assign do_shift = (state_q == SHIFT) && latch && rise;
  assign last     = do_shift && (bit_cnt_q == CW'(DATA_WIDTH - 1));
  assign abort    = busy && (!latch || (!rise && to_q == TW'(TIMEOUT_CYCLES - 1)));
  assign load     = last && (!dataValid || dataReady);
  assign drop     = last && dataValid && !dataReady;
  // Two-flop synchronizers; serClk carries a third stage for rising-edge detection
  always_ff @(posedge clk) begin
    if (!reset) begin
      sclk_q <= '0;
      sdat_q <= '0;
      slat_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], serClk};
      sdat_q <= {sdat_q[0], serData};
      slat_q <= {slat_q[0], serLatch};
    end
  end
  // Frame FSM, shift register, output handshake and error pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      to_q       <= '0;
      dataOut    <= '0;
      dataValid  <= 1'b0;
      overrun    <= 1'b0;
      frameError <= 1'b0;
    end else begin
      overrun    <= drop;
      frameError <= abort;
      dataValid  <= load || (dataValid && !dataReady);
      if (load) dataOut <= shift_d;
      if (state_q == IDLE) begin
        state_q   <= latch ? SHIFT : IDLE;
        bit_cnt_q <= '0;
        to_q      <= '0;
      end else if (!latch || abort) begin
        state_q   <= IDLE;
        bit_cnt_q <= '0;
        to_q      <= '0;
        shift_q   <= '0;
      end else if (rise) begin
        shift_q   <= shift_d;
        bit_cnt_q <= last ? '0 : bit_cnt_q + CW'(1);
        to_q      <= '0;
      end else begin
        to_q <= (bit_cnt_q == '0) ? '0 : to_q + TW'(1);
      end
    end
  end
endmodule

// File: tb/tb_shift_rx_deserializer.sv
// tb_shift_rx_deserializer: directed and randomized frames checked against a transaction-level model
module tb_shift_rx_deserializer;
  localparam int W = 8;
  logic clk = 0, reset = 0, serClk = 0, serData = 0, serLatch = 0, dataReady = 0;
  logic [W-1:0] dataOut;
  logic dataValid, overrun, frameError;
  int cyc, errs, checks, n_ovr, n_fe, n_vhi, fe_cyc, v_cyc, rise_c;
  logic prev_v;
  logic [W-1:0] got_q[$];

  shift_rx_deserializer #(.DATA_WIDTH(W), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .serClk(serClk), .serData(serData), .serLatch(serLatch),
    .dataOut(dataOut), .dataValid(dataValid), .dataReady(dataReady),
    .overrun(overrun), .frameError(frameError)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observe the consumer side between edges: accepted words, pulses, valid timing
  always @(negedge clk) begin
    if (reset) begin
      if (dataValid && dataReady) got_q.push_back(dataOut);
      if (overrun) n_ovr++;
      if (frameError) begin n_fe++; fe_cyc = cyc; end
      if (dataValid) n_vhi++;
      if (dataValid && !prev_v) v_cyc = cyc;
    end
    prev_v = dataValid;
  end

  task automatic cyc_();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pop();
    if (got_q.size() == 0) return 'x;
    return 32'(got_q.pop_front());
  endfunction

  task automatic send_bit(input logic b, input int lo, input int hi, input bit pr);
    serData = b;
    serClk  = 0;
    repeat (lo) cyc_();
    serClk = 1;
    rise_c = cyc;
    for (int i = 0; i < hi; i++) begin
      if (pr && i == 2) dataReady = 1;
      if (pr && i == 3) dataReady = 0;
      cyc_();
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input int lo, input int hi, input bit pr);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i], lo, hi, pr && i == 0);
  endtask

  initial begin
    int ovr0, fe0, vhi0, c, lo, hi;
    logic [W-1:0] w1, w2;
    repeat (3) cyc_();
    check("rst_dataOut", dataOut, 0);
    check("rst_dataValid", dataValid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frameError", frameError, 0);
    reset = 1; serLatch = 1; dataReady = 1;
    repeat (4) cyc_();
    vhi0 = n_vhi;
    send_word(8'hA5, 4, 4, 0);
    c = rise_c;
    repeat (3) cyc_();
    check("a5_data", pop(), 8'hA5);
    check("a5_latency", v_cyc, c + 3);
    check("a5_valid_len", n_vhi - vhi0, 1);
    dataReady = 0;
    ovr0 = n_ovr;
    send_word(8'h3C, 4, 4, 0);
    send_word(8'hC3, 4, 4, 0);
    repeat (3) cyc_();
    check("b2b_dataOut", dataOut, 8'h3C);
    check("b2b_valid", dataValid, 1);
    check("b2b_overrun", n_ovr - ovr0, 1);
    dataReady = 1; cyc_(); dataReady = 0; cyc_();
    check("b2b_pop", pop(), 8'h3C);
    check("b2b_valid_clr", dataValid, 0);
    w1 = 8'($urandom); w2 = 8'($urandom);
    ovr0 = n_ovr;
    send_word(w1, 4, 4, 0);
    send_word(w2, 4, 4, 1);
    repeat (2) cyc_();
    check("same_edge_pop_w1", pop(), w1);
    check("same_edge_dataOut", dataOut, w2);
    check("same_edge_valid", dataValid, 1);
    check("same_edge_overrun", n_ovr - ovr0, 0);
    dataReady = 1; cyc_();
    check("same_edge_pop_w2", pop(), w2);
    fe0 = n_fe; vhi0 = n_vhi;
    for (int i = 0; i < 5; i++) send_bit(1'(i % 2), 4, 4, 0);
    serClk = 0; serLatch = 0;
    repeat (6) cyc_();
    check("latch_drop_fe", n_fe - fe0, 1);
    check("latch_drop_novalid", n_vhi - vhi0, 0);
    serLatch = 1;
    repeat (4) cyc_();
    send_word(8'h81, 4, 4, 0);
    repeat (3) cyc_();
    check("after_fe_pop", pop(), 8'h81);
    fe0 = n_fe;
    for (int i = 0; i < 3; i++) send_bit(1'b1, 4, 4, 0);
    c = rise_c;
    serClk = 0;
    for (int i = 0; i < 200 && n_fe == fe0; i++) cyc_();
    check("timeout_cycle", fe_cyc, c + 3 + 64);
    repeat (3) cyc_();
    check("timeout_fe_once", n_fe - fe0, 1);
    w1 = 8'($urandom);
    send_word(w1, 4, 4, 0);
    repeat (3) cyc_();
    check("after_timeout_pop", pop(), w1);
    dataReady = 0;
    send_word(8'($urandom), 4, 4, 0);
    ovr0 = n_ovr; fe0 = n_fe;
    for (int i = 0; i < 4; i++) send_bit(1'b0, 4, 4, 0);
    reset = 0; serClk = 0;
    cyc_();
    check("midrst_dataOut", dataOut, 0);
    check("midrst_dataValid", dataValid, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_frameError", frameError, 0);
    reset = 1; dataReady = 1;
    repeat (4) cyc_();
    send_word(8'h5A, 4, 4, 0);
    repeat (3) cyc_();
    check("midrst_pop", pop(), 8'h5A);
    check("midrst_no_overrun", n_ovr - ovr0, 0);
    check("midrst_no_fe", n_fe - fe0, 0);
    ovr0 = n_ovr;
    for (int k = 0; k < 6; k++) begin
      w1 = 8'($urandom);
      lo = $urandom_range(2, 6);
      hi = $urandom_range(2, 6);
      send_word(w1, lo, hi, 0);
      repeat (3) cyc_();
      check("rand_pop", pop(), w1);
    end
    check("rand_no_overrun", n_ovr - ovr0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
